// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  // Arbiter control states; ABORT is only reachable with the watchdog built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Bits needed to index n items (never less than one).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the search starts just after `last`
// and wraps, so the most recent owner has the lowest priority.
module rr_pick import wb_arb_pkg::*; #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // First requester found walking last+1, last+2, ... modulo N wins.
  always_comb begin
    int unsigned j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      j = 32'(last) + i;
      if (j >= N) begin
        j = j - N;
      end
      if (!valid && req[IW'(j)]) begin
        onehot[IW'(j)] = 1'b1;
        idx            = IW'(j);
        valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master Wishbone B4 classic arbiter with round-robin priority. The grant is
// held for the owner's whole bus cycle; handover costs one cycle with s_cyc low.
// Optional slave watchdog: define WB_TIMEOUT_EN to build it in.
module wb_rr_arbiter import wb_arb_pkg::*; #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_w,
  output logic [DATA_W-1:0]               m_dat_r,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_adr,
  output logic [DATA_W/8-1:0]             s_sel,
  output logic [DATA_W-1:0]               s_dat_w,
  input  logic [DATA_W-1:0]               s_dat_r,
  input  logic                            s_ack,
  input  logic                            s_err,
  output logic [NUM_MASTERS-1:0]          grant
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
  localparam int unsigned SEL_W = DATA_W / 8;

  // Illegal parameter combinations leave an empty marker block in the hierarchy.
  if (NUM_MASTERS < 2 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
  end

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   owner_cyc;
  logic                   owner_stb;
  logic [IDX_W-1:0]       mux_idx;
  logic                   release_c;
  logic                   timeout_c;

  // `last` always names the current owner while the bus is held.
  assign owner_cyc = (state_q != IDLE) && m_cyc[last_q];
  assign owner_stb = m_stb[last_q];
  assign mux_idx   = (state_q == IDLE) ? '0 : last_q;
  assign m_dat_r   = s_dat_r;
  assign grant     = grant_q;

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req    (m_cyc),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = idx_width(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             stall_c;

  // Count consecutive stalled strobes; the limit-th one trips the watchdog.
  always_comb begin
    stall_c   = (state_q == BUSY) && owner_cyc && owner_stb && !s_ack && !s_err;
    timeout_c = stall_c && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    wd_cnt_d  = (stall_c && !timeout_c) ? wd_cnt_q + CNT_W'(1) : '0;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state, grant rotation and slave/master routing.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    release_c = 1'b0;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = m_we[mux_idx];
    s_adr     = m_adr[32'(mux_idx) * ADDR_W +: ADDR_W];
    s_sel     = m_sel[32'(mux_idx) * SEL_W +: SEL_W];
    s_dat_w   = m_dat_w[32'(mux_idx) * DATA_W +: DATA_W];
    m_ack     = '0;
    m_err     = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          last_d  = pick_idx;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (owner_cyc) begin
          if (timeout_c) begin
            m_err[last_q] = 1'b1;
            state_d       = ABORT;
          end else begin
            s_cyc         = 1'b1;
            s_stb         = owner_stb;
            m_ack[last_q] = s_ack;
            m_err[last_q] = s_err;
          end
        end else begin
          release_c = 1'b1;
        end
      end

`ifdef WB_TIMEOUT_EN
      ABORT: begin
        if (!owner_cyc) begin
          release_c = 1'b1;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Owner has let go: hand over to the next requester or fall back to idle.
    if (release_c) begin
      if (pick_valid) begin
        grant_d = pick_onehot;
        last_d  = pick_idx;
        state_d = BUSY;
      end else begin
        grant_d = '0;
        state_d = IDLE;
      end
    end
  end

  // Control state registers; master 0 wins first out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised N-master Wishbone B4 (classic, non-pipelined) arbiter for the SoC memory path. It generalises the fixed two-master instruction/data arbiter to NUM_MASTERS requesters with rotating (round-robin) priority. It holds each grant for the owner's whole bus cycle, and has an optional slave-timeout watchdog. It sits between the CPU-side buses (instruction bus, crossbar memory port, future DMA) and a single slave such as the RAM.

## Interface
- NUM_MASTERS, 2: number of requesters; must be at least 2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255: watchdog limit in stalled cycles; must be at least 1; used only with WB_TIMEOUT_EN.
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- m_cyc  in  NUM_MASTERS  per-master CYC.
- m_stb  in  NUM_MASTERS  per-master STB.
- m_we  in  NUM_MASTERS  per-master WE.
- m_adr  in  NUM_MASTERS*ADDR_W  packed addresses; master i occupies slice [i*ADDR_W +: ADDR_W].
- m_sel  in  NUM_MASTERS*DATA_W/8  packed byte selects.
- m_dat_w  in  NUM_MASTERS*DATA_W  packed write data.
- m_dat_r  out  DATA_W  read data, shared by all masters; equals s_dat_r.
- m_ack  out  NUM_MASTERS  per-master ACK; asserted only on the owner's bit.
- m_err  out  NUM_MASTERS  per-master ERR; asserted only on the owner's bit.
- s_cyc, s_stb, s_we  out  1  slave-side controls.
- s_adr  out  ADDR_W  slave-side address.
- s_sel  out  DATA_W/8  slave-side byte selects.
- s_dat_w  out  DATA_W  slave-side write data.
- s_dat_r  in  DATA_W  slave read data.
- s_ack, s_err  in  1  slave responses.
- grant  out  NUM_MASTERS  registered one-hot owner vector; all zero when no master owns the bus.

## Operation
- The state machine has three states: IDLE, BUSY and ABORT. ABORT exists only with WB_TIMEOUT_EN.
- Rotating pointer `last` holds the index of the most recent owner.
- Arbitration searches m_cyc starting at index last+1 and wrapping modulo NUM_MASTERS. The first master with CYC set wins.
- IDLE: if any m_cyc is set, register the winner in grant, update `last`, and go to BUSY. Otherwise stay in IDLE.
- BUSY, while the owner's m_cyc is 1:
  - s_cyc equals the owner's CYC; s_stb/s_we/s_adr/s_sel/s_dat_w are the owner's slices, muxed combinationally.
  - s_ack and s_err are routed to the owner's bit of m_ack/m_err.
  - All other masters see ACK=0 and ERR=0, and their CYC/STB are ignored.
- BUSY, when the owner's m_cyc is 0:
  - s_cyc = 0 in that cycle.
  - If any other master requests, arbitrate immediately and register the new grant at the next edge. Handover costs exactly one cycle with s_cyc low.
  - If no master requests, clear grant and go to IDLE.
- A grant is never revoked while the owner's CYC is high, except by the watchdog.
- While grant is zero: s_cyc=0, s_stb=0, m_ack=0 and m_err=0. s_adr/s_sel/s_dat_w are don't-care but are driven from master 0 (no X).
- Simultaneous requests from every master with `last`=k: master (k+1) mod NUM_MASTERS wins.

## Timing
- Reset values: grant=0, s_cyc=0, s_stb=0, m_ack=0, m_err=0, state IDLE, `last`=NUM_MASTERS-1, so master 0 wins first. Watchdog counter=0.
- Reset is asynchronous. Asserting it mid-transfer drops s_cyc in the same cycle with no handshake.
- Grant latency: a request seen in IDLE at edge n produces grant and s_cyc at edge n+1.
- Slave responses and control forwarding add zero cycles. ACK is combinational from s_ack.

## Configuration
- WB_TIMEOUT_EN defined:
  - A counter increments on each cycle with s_cyc & s_stb & ~s_ack & ~s_err, and clears on any of those three being false.
  - When the counter reaches TIMEOUT_CYCLES, pulse the owner's m_err for one cycle, force s_cyc and s_stb low, and enter ABORT.
  - ABORT holds s_cyc low until the owner drops m_cyc, then behaves as the BUSY release path.
- WB_TIMEOUT_EN undefined: no counter and no ABORT state. A hung slave holds the grant indefinitely.

## Structure
- Package wb_arb_pkg holds the arb_state_t enum (IDLE, BUSY, ABORT) and a clog2-based index-width localparam helper.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req vector and `last`.
  - Outputs: one-hot winner, winner index, and a valid flag.

## Test plan
- Reset, then master 0 and master 1 both raise cyc/stb for a read of 0x100:
  - grant=01 one cycle later.
  - s_adr=0x100.
  - On slave ACK, m_ack=01 and m_dat_r equals s_dat_r.
- Master 0 drops cyc while master 1 is still requesting:
  - Exactly one cycle of s_cyc=0.
  - Then grant=10 and master 1's write of 0xDEADBEEF reaches s_dat_w with s_sel=4'hF.
- NUM_MASTERS=4, all masters requesting continuously, each doing one transfer: grant order is 0,1,2,3,0 with no master starved.
- Master 2 raises stb while master 0 owns the bus:
  - Master 2 gets no ACK.
  - The slave never sees master 2's address until master 0 releases.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and the slave never ACKs:
  - Owner's m_err pulses on the 8th stalled cycle and s_cyc drops.
  - The next master is granted after the owner releases.
- Assert rst mid-transfer: grant, s_cyc and m_ack go to 0 immediately; after release master 0 wins first.
